// File: rtl/program_loader_pkg.sv
// Shared definitions for the host-side program loader: FSM states and default sizing.
package program_loader_pkg;

    localparam int unsigned DEF_DEPTH      = 16;
    localparam int unsigned DEF_ADDR_W     = 4;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        LOAD   = 2'd2,
        FINISH = 2'd3
    } loader_state_t;

endpackage

// File: rtl/program_loader_sync_fifo.sv
// Byte FIFO buffering host program bytes; head is visible combinationally on rdata.
module sync_fifo
    import program_loader_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [7:0]     mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           do_push;
    logic           do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{PTR_W{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{PTR_W{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/program_loader.sv
// Host-side loader: buffers host bytes and feeds one per control-block programming slot
// until DEPTH words have been written.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic            ext_valid,
    input  logic [7:0]      ext_data,
    output logic            ext_ready,
    input  logic            ready,
    input  logic            read_ui_in,
    input  logic            done_load,
    output logic            programming,
    output logic [7:0]      bus_data,
    output logic            bus_drive,
    output logic [ADDR_W:0] load_count,
    output logic            prog_done,
    output logic            underrun
);

    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(DEPTH - 1);

    loader_state_t state;
    loader_state_t next_state;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;
    logic          in_load;

    assign in_load   = (state == LOAD);
    assign ext_ready = !fifo_full;
    assign bus_drive = read_ui_in && in_load;
    assign bus_data  = fifo_empty ? 8'h00 : fifo_head;

    sync_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (ext_valid && ext_ready),
        .pop    (in_load && done_load),
        .wdata  (ext_data),
        .rdata  (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ARM;
            ARM:     if (ready && !fifo_empty) next_state = LOAD;
            LOAD:    if (done_load && (load_count == LAST_WORD)) next_state = FINISH;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // programming and prog_done are registered decodes of the upcoming state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            programming <= 1'b0;
            prog_done   <= 1'b0;
            load_count  <= '0;
            underrun    <= 1'b0;
        end else begin
            state       <= next_state;
            programming <= (next_state != IDLE);
            prog_done   <= (next_state == FINISH);
            if ((state == IDLE) && start) begin
                load_count <= '0;
                underrun   <= 1'b0;
            end else if (in_load) begin
                if (read_ui_in && fifo_empty) underrun <= 1'b1;
                if (done_load) load_count <= load_count + {{ADDR_W{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a six-cycle control-block model and a host byte driver.
module tb_program_loader;

    logic       clk;
    logic       resetn;
    logic       start;
    logic       ext_valid;
    logic [7:0] ext_data;
    logic       ext_ready;
    logic       ready;
    logic       read_ui_in;
    logic       done_load;
    logic       programming;
    logic [7:0] bus_data;
    logic       bus_drive;
    logic [4:0] load_count;
    logic       prog_done;
    logic       underrun;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned pulse_cnt = 0;
    logic [7:0]  host_q[$];
    logic [7:0]  exp_q[$];
    logic        acc;

    program_loader #(
        .DEPTH      (16),
        .ADDR_W     (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .ext_valid   (ext_valid),
        .ext_data    (ext_data),
        .ext_ready   (ext_ready),
        .ready       (ready),
        .read_ui_in  (read_ui_in),
        .done_load   (done_load),
        .programming (programming),
        .bus_data    (bus_data),
        .bus_drive   (bus_drive),
        .load_count  (load_count),
        .prog_done   (prog_done),
        .underrun    (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (prog_done) pulse_cnt++;

    // Host driver: offers the queue head each cycle, drops it once accepted.
    initial begin
        ext_valid = 1'b0;
        ext_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (host_q.size() > 0) begin
                ext_valid = 1'b1;
                ext_data  = host_q[0];
            end else begin
                ext_valid = 1'b0;
            end
            #4;
            acc = ext_valid && ext_ready;
            @(posedge clk);
            if (acc && host_q.size() > 0) host_q.delete(0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One instruction cycle T0..T5 of the control block; indicators change on negedge.
    task automatic cb_cycle(output logic [7:0] d, output logic dr);
        @(negedge clk) ready = 1'b1;
        @(negedge clk) ready = 1'b0;
        @(negedge clk);
        @(negedge clk) read_ui_in = 1'b1;
        #1;
        d  = bus_data;
        dr = bus_drive;
        @(negedge clk) begin read_ui_in = 1'b0; done_load = 1'b1; end
        @(negedge clk) done_load = 1'b0;
    endtask

    task automatic run_slots(input int n);
        logic [7:0] d;
        logic       dr;
        for (int i = 0; i < n; i++) begin
            cb_cycle(d, dr);
            check("slot_drive", {31'd0, dr}, 32'd1);
            check("slot_byte", {24'd0, d}, {24'd0, exp_q.pop_front()});
        end
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        #1;
        pulse_cnt = 0;
        check("start_programming", {31'd0, programming}, 32'd1);
    endtask

    task automatic end_session(input logic exp_underrun);
        #1;
        check("end_prog_done", {31'd0, prog_done}, 32'd1);
        check("end_count", {27'd0, load_count}, 32'd16);
        check("end_programming_held", {31'd0, programming}, 32'd1);
        @(negedge clk) #1;
        check("after_prog_done", {31'd0, prog_done}, 32'd0);
        check("after_programming", {31'd0, programming}, 32'd0);
        check("done_pulses", pulse_cnt, 32'd1);
        check("end_underrun", {31'd0, underrun}, {31'd0, exp_underrun});
    endtask

    initial begin
        logic [7:0] d;
        logic       dr;
        resetn = 1'b0; start = 1'b0; ready = 1'b0; read_ui_in = 1'b0; done_load = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Asynchronous reset from a non-idle state with a buffered byte
        host_q.push_back(8'hC3);
        repeat (3) @(negedge clk);
        do_start();
        check("pre_reset_bus", {24'd0, bus_data}, 32'hC3);
        @(posedge clk) #2 resetn = 1'b0;
        #1;
        check("rst_programming", {31'd0, programming}, 32'd0);
        check("rst_bus_data", {24'd0, bus_data}, 32'h00);
        check("rst_bus_drive", {31'd0, bus_drive}, 32'd0);
        check("rst_ext_ready", {31'd0, ext_ready}, 32'd1);
        check("rst_count", {27'd0, load_count}, 32'd0);
        check("rst_prog_done", {31'd0, prog_done}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        @(negedge clk) resetn = 1'b1;

        // Full session: two preloaded bytes, then a stream
        host_q.push_back(8'h4E);
        host_q.push_back(8'h2F);
        repeat (3) @(negedge clk);
        exp_q = {8'h4E, 8'h2F};
        for (int i = 0; i < 14; i++) begin
            host_q.push_back(8'h10 + 8'(i));
            exp_q.push_back(8'h10 + 8'(i));
        end
        do_start();
        run_slots(16);
        end_session(1'b0);

        // FIFO full: fifth byte is held off
        @(posedge clk) #2;
        for (int i = 0; i < 5; i++) host_q.push_back(8'hA0 + 8'(i));
        repeat (8) @(negedge clk);
        #1;
        check("full_ext_ready", {31'd0, ext_ready}, 32'd0);
        check("full_pending", host_q.size(), 32'd1);
        @(posedge clk) #2 host_q.delete();
        @(negedge clk);
        exp_q = {8'hA0, 8'hA1, 8'hA2, 8'hA3};
        for (int i = 0; i < 12; i++) begin
            host_q.push_back(8'h30 + 8'(i));
            exp_q.push_back(8'h30 + 8'(i));
        end
        do_start();
        run_slots(16);
        end_session(1'b0);

        // Underrun: a single byte for a sixteen-word session
        host_q.push_back(8'h55);
        repeat (3) @(negedge clk);
        do_start();
        exp_q = {8'h55};
        run_slots(1);
        check("underrun_slot0", {31'd0, underrun}, 32'd0);
        exp_q = {8'h00};
        run_slots(1);
        check("underrun_slot1", {31'd0, underrun}, 32'd1);
        for (int i = 0; i < 14; i++) exp_q.push_back(8'h00);
        run_slots(14);
        end_session(1'b1);

        // ARM gating: empty FIFO holds the loader in ARM
        do_start();
        check("restart_clears_underrun", {31'd0, underrun}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cb_cycle(d, dr);
            check("arm_no_drive", {31'd0, dr}, 32'd0);
        end
        check("arm_count", {27'd0, load_count}, 32'd0);
        host_q.push_back(8'h77);
        repeat (3) @(negedge clk);
        exp_q = {8'h77};
        for (int i = 0; i < 15; i++) exp_q.push_back(8'h00);
        run_slots(16);
        end_session(1'b1);

        // Reset mid-session after seven words
        for (int i = 0; i < 16; i++) host_q.push_back(8'h60 + 8'(i));
        repeat (6) @(negedge clk);
        do_start();
        exp_q = {};
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h60 + 8'(i));
        run_slots(7);
        #1;
        check("mid_count", {27'd0, load_count}, 32'd7);
        host_q.delete();
        @(negedge clk);
        @(posedge clk) #2 resetn = 1'b0;
        #1;
        check("mid_rst_programming", {31'd0, programming}, 32'd0);
        check("mid_rst_count", {27'd0, load_count}, 32'd0);
        check("mid_rst_ext_ready", {31'd0, ext_ready}, 32'd1);
        check("mid_rst_bus_data", {24'd0, bus_data}, 32'h00);
        @(negedge clk) resetn = 1'b1;
        host_q.push_back(8'h99);
        repeat (3) @(negedge clk);
        do_start();
        exp_q = {8'h99};
        run_slots(1);
        #1;
        check("restart_count", {27'd0, load_count}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
